psum_acc_buffer: RTL and testbench

//  Partial-sum store on the far side of adder_tree_4: supplies psum into tree level 3 and captures acc/vld

---
 rtl/psum_acc_buffer.sv | 241 ++++++++++++++++++++++++
 tb/tb_psum_acc_buffer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_acc_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : psum_acc_buffer                                            |
// | Description : Partial-sum store on the far side of adder_tree_4. Feeds   |
// |               psum into tree level 3, captures acc back, accumulates     |
// |               over cfg_npass passes of cfg_len positions, then drains    |
// |               the final sums over a valid/ready port.                    |
// | Options     : PSUM_RELU_EN - drained words with sign bit set output as 0 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module psum_acc_buffer #(
  parameter int W_PSUM = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_start,
  input  logic [7:0]        cfg_npass,
  input  logic [AW:0]       cfg_len,
  input  logic              tree_vld_i,
  output logic [W_PSUM-1:0] psum_o,
  input  logic [W_PSUM-1:0] acc_i,
  input  logic              acc_vld_i,
  output logic [W_PSUM-1:0] out_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [AW:0]   c_MIN_LEN = (AW+1)'(2);
  localparam logic [AW:0]   c_MAX_LEN = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] c_ONE_A   = AW'(1);
  localparam logic [AW-1:0] c_ZERO_A  = '0;

  state_t            r_state;
  state_t            w_state_nxt;

  // latched configuration, stored as last index / last pass
  logic [AW-1:0]     r_len_m1;
  logic [7:0]        r_npass_m1;

  // read (issue) side
  logic [AW-1:0]     r_rd_ptr;
  logic [7:0]        r_rd_pass;
  logic              r_rd_done;
  logic              r_s1_vld;
  logic              r_s1_zero;
  logic [AW-1:0]     r_s1_addr;
  logic [W_PSUM-1:0] r_psum;

  // write (capture) side
  logic [AW-1:0]     r_wr_ptr;
  logic [7:0]        r_wr_pass;

  // drain side
  logic [AW-1:0]     r_drn_ptr;
  logic [W_PSUM-1:0] r_out_data;
  logic              r_out_vld;
  logic              r_done;
  logic              r_err;

  logic [W_PSUM-1:0] r_mem [DEPTH];

  logic              w_cfg_ok;
  logic              w_start_ok;
  logic              w_start_bad;
  logic              w_issue;
  logic              w_stray;
  logic              w_wr;
  logic              w_final_wr;
  logic              w_accept;
  logic              w_last_beat;
  logic [AW-1:0]     w_drn_nxt;

  assign w_cfg_ok    = (cfg_len >= c_MIN_LEN) && (cfg_len <= c_MAX_LEN) && (cfg_npass != 8'd0);
  assign w_start_ok  = (r_state == S_IDLE) && cfg_start && w_cfg_ok;
  assign w_start_bad = (r_state == S_IDLE) && cfg_start && !w_cfg_ok;
  assign w_issue     = tree_vld_i && (r_state == S_ACCUM) && !r_rd_done;
  assign w_stray     = tree_vld_i && !w_issue;
  assign w_wr        = acc_vld_i && (r_state == S_ACCUM);
  assign w_final_wr  = w_wr && (r_wr_ptr == r_len_m1) && (r_wr_pass == r_npass_m1);
  assign w_accept    = (r_state == S_DRAIN) && r_out_vld && out_rdy;
  assign w_last_beat = w_accept && (r_drn_ptr == r_len_m1);
  assign w_drn_nxt   = r_drn_ptr + c_ONE_A;

  assign psum_o   = r_psum;
  assign out_data = r_out_data;
  assign out_vld  = r_out_vld;
  assign done     = r_done;
  assign err      = r_err;

  // Drained-word shaping: optional ReLU clamp on the way out only.
  function automatic logic [W_PSUM-1:0] f_drain_word(input logic [W_PSUM-1:0] v);
`ifdef PSUM_RELU_EN
    f_drain_word = v[W_PSUM-1] ? '0 : v;
`else
    f_drain_word = v;
`endif
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and busy flag.
  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (w_start_ok)  w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_final_wr)  w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_beat) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture run configuration on an accepted start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_len_m1   <= '0;
      r_npass_m1 <= '0;
    end else if (w_start_ok) begin
      r_len_m1   <= cfg_len[AW-1:0] - c_ONE_A;
      r_npass_m1 <= cfg_npass - 8'd1;
    end
  end

  // Issue pointer: walk positions, wrap into the next pass, stop after the last pass.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr  <= '0;
      r_rd_pass <= '0;
      r_rd_done <= 1'b0;
    end else if (w_start_ok) begin
      r_rd_ptr  <= '0;
      r_rd_pass <= '0;
      r_rd_done <= 1'b0;
    end else if (w_issue) begin
      if (r_rd_ptr == r_len_m1) begin
        r_rd_ptr  <= '0;
        r_rd_pass <= r_rd_pass + 8'd1;
        if (r_rd_pass == r_npass_m1) r_rd_done <= 1'b1;
      end else begin
        r_rd_ptr <= r_rd_ptr + c_ONE_A;
      end
    end
  end

  // Stage 1: register the read address and first-pass flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_vld  <= 1'b0;
      r_s1_zero <= 1'b0;
      r_s1_addr <= '0;
    end else begin
      r_s1_vld  <= w_issue;
      r_s1_zero <= (r_rd_pass == 8'd0);
      r_s1_addr <= r_rd_ptr;
    end
  end

  // Stage 2: psum to the tree; forward acc_i when it lands on the address being read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_psum <= '0;
    end else if (r_s1_vld) begin
      if (r_s1_zero)                            r_psum <= '0;
      else if (w_wr && (r_wr_ptr == r_s1_addr)) r_psum <= acc_i;
      else                                      r_psum <= r_mem[r_s1_addr];
    end
  end

  // Store write port (contents intentionally not reset).
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= acc_i;
  end

  // Write pointer follows tree results in issue order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr  <= '0;
      r_wr_pass <= '0;
    end else if (w_start_ok) begin
      r_wr_ptr  <= '0;
      r_wr_pass <= '0;
    end else if (w_wr) begin
      if (r_wr_ptr == r_len_m1) begin
        r_wr_ptr  <= '0;
        r_wr_pass <= r_wr_pass + 8'd1;
      end else begin
        r_wr_ptr <= r_wr_ptr + c_ONE_A;
      end
    end
  end

  // Drain: preload entry 0 on the first DRAIN cycle, then advance one entry per accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_data <= '0;
      r_out_vld  <= 1'b0;
      r_drn_ptr  <= '0;
    end else if (r_state == S_DRAIN) begin
      if (!r_out_vld) begin
        r_out_data <= f_drain_word(r_mem[c_ZERO_A]);
        r_out_vld  <= 1'b1;
        r_drn_ptr  <= '0;
      end else if (w_accept) begin
        if (r_drn_ptr == r_len_m1) begin
          r_out_vld <= 1'b0;
        end else begin
          r_drn_ptr  <= w_drn_nxt;
          r_out_data <= f_drain_word(r_mem[w_drn_nxt]);
        end
      end
    end
  end

  // Status pulses: done after the final accept, err on bad start or stray issue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_last_beat;
      r_err  <= w_start_bad | w_stray;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psum_acc_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_psum_acc_buffer                                         |
// | Description : Self-checking bench for psum_acc_buffer with a behavioural |
// |               adder-tree stand-in and a pass-sum reference model.        |
// | Options     : PSUM_RELU_EN - expected drained values clamp negatives.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_psum_acc_buffer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_start;
  logic [7:0]  cfg_npass;
  logic [6:0]  cfg_len;
  logic        tree_vld_i;
  logic [31:0] psum_o;
  logic [31:0] acc_i;
  logic        acc_vld_i;
  logic [31:0] out_data;
  logic        out_vld;
  logic        out_rdy;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  // per-pass, per-position contribution the tree adds on top of psum
  logic [31:0] dtab [256][64];

`ifdef PSUM_RELU_EN
  localparam logic [31:0] c_NEG7_OUT = 32'd0;
`else
  localparam logic [31:0] c_NEG7_OUT = 32'hFFFF_FFF9;
`endif

  typedef struct {
    int          npass;
    int          len;
    logic [31:0] d0;
    logic [31:0] step;
    int          rdy_mode;
    int          gap_pct;
    bit          stress;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[8];
  int   bad_len[5] = '{1, 0, 65, 2, 127};
  int   bad_np[5]  = '{1, 1, 1, 0, 3};

  psum_acc_buffer #(.W_PSUM(32), .DEPTH(64), .AW(6)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cfg_start  (cfg_start),
    .cfg_npass  (cfg_npass),
    .cfg_len    (cfg_len),
    .tree_vld_i (tree_vld_i),
    .psum_o     (psum_o),
    .acc_i      (acc_i),
    .acc_vld_i  (acc_vld_i),
    .out_data   (out_data),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%08h), want %0d (0x%08h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Accumulated value of a position after 'upto' passes.
  function automatic logic [31:0] model_sum(input int upto, input int pos);
    logic [31:0] s;
    s = 32'd0;
    for (int q = 0; q < upto; q++) s = s + dtab[q][pos];
    return s;
  endfunction

  function automatic logic [31:0] drained(input logic [31:0] v);
`ifdef PSUM_RELU_EN
    if ($signed(v) < 0) return 32'd0;
`endif
    return v;
  endfunction

  task automatic fill_lin(input int npass, input int len, input logic [31:0] d0, input logic [31:0] step);
    for (int q = 0; q < npass; q++)
      for (int k = 0; k < len; k++)
        dtab[q][k] = d0 + 32'(k) * step;
  endtask

  // One full job: start, issue with optional gaps, emulate the tree, check psum and drain.
  task automatic do_run(input int npass, input int len, input int rdy_mode, input int gap_pct,
                        input bit stress, output logic [31:0] first_b, output logic [31:0] last_b);
    int total, issued, wrs, beats, dones, errs, cyc, f_cyc, first_vld_cyc, budget;
    bit h1_v, h2_v, cur_v, pend_v, prev_stall, fin, timed_out, extra_left, mid_done;
    int h1_p, h1_k, h2_p, h2_k, cur_p, cur_k;
    logic [31:0] pend_acc, acc_new, prev_data;
    total = npass * len;
    issued = 0; wrs = 0; beats = 0; dones = 0; errs = 0; cyc = 0;
    f_cyc = -100; first_vld_cyc = -1;
    budget = total * 4 + len * 8 + 200;
    h1_v = 0; h2_v = 0; pend_v = 0; prev_stall = 0; fin = 0; timed_out = 0;
    h1_p = 0; h1_k = 0; h2_p = 0; h2_k = 0; cur_p = 0; cur_k = 0;
    pend_acc = 0; prev_data = 0;
    extra_left = stress; mid_done = 0;
    first_b = 0; last_b = 0;

    cfg_npass = 8'(npass);
    cfg_len   = 7'(len);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);

    while (!fin) begin
      // tree: result for the issue two cycles back is driven on the next cycle
      acc_new = 32'd0;
      if (h2_v) begin
        chk("psum", psum_o, model_sum(h2_p, h2_k));
        acc_new = psum_o + dtab[h2_p][h2_k];
      end
      acc_vld_i = pend_v;
      acc_i     = pend_v ? pend_acc : $urandom();
      if (pend_v) begin
        wrs++;
        if (wrs == total) f_cyc = cyc;
      end
      pend_v   = h2_v;
      pend_acc = acc_new;

      // drain monitor
      if (prev_stall) begin
        chk("stall_vld", {31'd0, out_vld}, 32'd1);
        chk("stall_hold", out_data, prev_data);
      end
      if (out_vld && first_vld_cyc < 0) begin
        first_vld_cyc = cyc;
        chk("drain_latency", cyc, f_cyc + 2);
      end
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = (cyc % 2 == 0);
        default: out_rdy = ($urandom_range(0, 1) == 1);
      endcase
      if (out_vld && out_rdy) begin
        if (beats < len) chk("drain_data", out_data, drained(model_sum(npass, beats)));
        if (beats == 0) first_b = out_data;
        last_b = out_data;
        beats++;
      end
      prev_stall = out_vld && !out_rdy;
      prev_data  = out_data;
      if (err) errs++;
      if (done) begin
        dones++;
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("vld_at_done", {31'd0, out_vld}, 32'd0);
        fin = 1;
      end

      // issue side
      tree_vld_i = 1'b0;
      cur_v = 0;
      if (issued < total) begin
        if (gap_pct >= 100 || $urandom_range(0, 99) < gap_pct) begin
          tree_vld_i = 1'b1;
          cur_v = 1;
          cur_p = issued / len;
          cur_k = issued % len;
          issued++;
        end
      end else if (extra_left) begin
        tree_vld_i = 1'b1;
        extra_left = 0;
      end
      if (stress && !mid_done && issued == 2) begin
        cfg_start = 1'b1;
        cfg_len   = 7'd1;
        mid_done  = 1;
      end else begin
        cfg_start = 1'b0;
      end
      h2_v = h1_v; h2_p = h1_p; h2_k = h1_k;
      h1_v = cur_v; h1_p = cur_p; h1_k = cur_k;

      cyc++;
      if (!fin && cyc > budget) begin
        checks++;
        failures++;
        $display("FAIL timeout: run npass=%0d len=%0d beats=%0d want %0d", npass, len, beats, len);
        fin = 1;
        timed_out = 1;
      end
      tick();
    end

    tree_vld_i = 1'b0;
    acc_vld_i  = 1'b0;
    cfg_start  = 1'b0;
    out_rdy    = 1'b0;
    if (!timed_out) begin
      chk("done_width", {31'd0, done}, 32'd0);
      chk("beat_count", beats, len);
      chk("done_count", dones, 1);
      chk("err_count", errs, stress ? 1 : 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] fb, lb;
    int e;
    int np, ln, gp;

    vecs[0] = '{1,   4,  32'd10,        32'd10, 0, 100, 1'b0, 32'd10,     32'd40};
    vecs[1] = '{3,   4,  32'd5,         32'd0,  0, 100, 1'b0, 32'd15,     32'd15};
    vecs[2] = '{2,   2,  32'd7,         32'd3,  0, 100, 1'b0, 32'd14,     32'd20};
    vecs[3] = '{1,   4,  32'd10,        32'd10, 1, 100, 1'b0, 32'd10,     32'd40};
    vecs[4] = '{1,   2,  32'hFFFF_FFF9, 32'd0,  0, 100, 1'b0, c_NEG7_OUT, c_NEG7_OUT};
    vecs[5] = '{255, 2,  32'd1,         32'd1,  2, 100, 1'b0, 32'd255,    32'd510};
    vecs[6] = '{1,   64, 32'd1,         32'd1,  2, 100, 1'b0, 32'd1,      32'd64};
    vecs[7] = '{2,   3,  32'd100,       32'd50, 2, 70,  1'b1, 32'd200,    32'd400};

    rstn = 1'b0; cfg_start = 1'b0; cfg_npass = '0; cfg_len = '0;
    tree_vld_i = 1'b0; acc_i = '0; acc_vld_i = 1'b0; out_rdy = 1'b0;
    repeat (3) tick();
    chk("rst_psum", psum_o, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rstn = 1'b1;
    tick();

    // rejected configurations: one err pulse, stay idle
    for (int i = 0; i < 5; i++) begin
      cfg_npass = 8'(bad_np[i]);
      cfg_len   = 7'(bad_len[i]);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      e = 0;
      repeat (3) begin
        if (err) e++;
        chk("bad_cfg_busy", {31'd0, busy}, 32'd0);
        tick();
      end
      chk("bad_cfg_err", e, 1);
    end

    // stray issue while idle
    tree_vld_i = 1'b1;
    tick();
    tree_vld_i = 1'b0;
    e = 0;
    repeat (3) begin
      if (err) e++;
      tick();
    end
    chk("idle_issue_err", e, 1);
    chk("idle_issue_busy", {31'd0, busy}, 32'd0);

    // directed table
    for (int v = 0; v < 8; v++) begin
      fill_lin(vecs[v].npass, vecs[v].len, vecs[v].d0, vecs[v].step);
      do_run(vecs[v].npass, vecs[v].len, vecs[v].rdy_mode, vecs[v].gap_pct, vecs[v].stress, fb, lb);
      chk("table_first", fb, vecs[v].exp_first);
      chk("table_last", lb, vecs[v].exp_last);
      tick();
    end

    // reset in the middle of a multi-pass run, with tree results still in flight
    cfg_npass = 8'd3; cfg_len = 7'd2; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    tree_vld_i = 1'b1;
    repeat (4) tick();
    tree_vld_i = 1'b0;
    repeat (2) tick();
    acc_vld_i = 1'b1;
    acc_i = 32'd77;
    #2 rstn = 1'b0;
    tick();
    chk("midrst_psum", psum_o, 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_out_vld", {31'd0, out_vld}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    rstn = 1'b1;
    repeat (3) begin
      tick();
      chk("late_acc_busy", {31'd0, busy}, 32'd0);
      chk("late_acc_err", {31'd0, err}, 32'd0);
      chk("late_acc_vld", {31'd0, out_vld}, 32'd0);
    end
    acc_vld_i = 1'b0;
    fill_lin(1, 4, 32'd10, 32'd10);
    do_run(1, 4, 0, 100, 1'b0, fb, lb);
    chk("post_rst_first", fb, 32'd10);
    chk("post_rst_last", lb, 32'd40);
    tick();

    // randomized jobs against the pass-sum model
    for (int r = 0; r < 6; r++) begin
      np = int'($urandom_range(1, 5));
      ln = int'($urandom_range(2, 10));
      gp = int'($urandom_range(40, 100));
      for (int q = 0; q < np; q++)
        for (int k = 0; k < ln; k++)
          dtab[q][k] = $urandom();
      do_run(np, ln, 2, gp, 1'b0, fb, lb);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
